// File: rtl/vending_ctrl.sv
// ---------------------------------------------------------------------------
// vending_ctrl : parametrised coin-accumulating vending controller.
//
// Accepts three coin denominations, accumulates credit, dispenses when the
// credit reaches PRICE and returns change or a refund over a valid/ack
// handshake. All outputs are registered (Moore style).
//
// Optional feature macro: VEND_TIMEOUT_EN
//   defined   -> an inactivity counter forces a refund after TIMEOUT_CYC
//                consecutive COLLECT cycles without an accepted coin.
//   undefined -> COLLECT holds credit indefinitely.
//
// Ports:
//   clk          in   clock, rising edge
//   arstn        in   asynchronous active-low reset
//   coin_valid   in   coin presented this cycle
//   coin_sel     in   [1:0] denomination (2'b00 is invalid)
//   cancel       in   request refund of current credit (COLLECT only)
//   change_ack   in   change mechanism accepted change_amt
//   vend         out  one-cycle dispense pulse
//   coin_reject  out  one-cycle pulse, presented coin not accepted
//   change_valid out  change/refund pending
//   change_amt   out  [CW-1:0] change/refund value, 0 when change_valid=0
//   credit       out  [CW-1:0] current credit
//   busy         out  high in VEND or REFUND
// ---------------------------------------------------------------------------
module vending_ctrl #(
  parameter int CW          = 8,
  parameter int PRICE       = 15,
  parameter int COIN_A      = 5,
  parameter int COIN_B      = 10,
  parameter int COIN_C      = 25,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic          coin_valid,
  input  logic [1:0]    coin_sel,
  input  logic          cancel,
  input  logic          change_ack,
  output logic          vend,
  output logic          coin_reject,
  output logic          change_valid,
  output logic [CW-1:0] change_amt,
  output logic [CW-1:0] credit,
  output logic          busy
);

  if (PRICE < 1 || PRICE > (1 << CW) - 1) begin : g_bad_price
    $error("vending_ctrl: PRICE out of range 1..2^CW-1");
  end
  if (COIN_A == 0 || COIN_B == 0 || COIN_C == 0) begin : g_bad_coin
    $error("vending_ctrl: coin values must be non-zero");
  end

  localparam logic [CW-1:0] PRICE_W = CW'(PRICE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] credit_nxt;
  logic [CW:0]   sum;
  logic          accept;
  logic          reject_nxt;
  logic          tmo_hit;

  // Coin value widened to CW+1 bits so the credit sum can expose overflow.
  function automatic logic [CW:0] coin_value(input logic [1:0] sel);
    case (sel)
      2'b01:   coin_value = (CW+1)'(COIN_A);
      2'b10:   coin_value = (CW+1)'(COIN_B);
      2'b11:   coin_value = (CW+1)'(COIN_C);
      default: coin_value = '0;
    endcase
  endfunction

`ifdef VEND_TIMEOUT_EN
  if (TIMEOUT_CYC < 1) begin : g_bad_tmo
    $error("vending_ctrl: TIMEOUT_CYC must be at least 1");
  end

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // The counter holds the number of COLLECT cycles already elapsed, so the
  // cycle in which it reads TIMEOUT_CYC-1 is the last one allowed.
  assign tmo_hit = (state == COLLECT) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tmo_cnt <= '0;
    end else if (state_nxt == COLLECT && (state != COLLECT || accept)) begin
      tmo_cnt <= '0;
    end else if (state == COLLECT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    sum        = {1'b0, credit} + coin_value(coin_sel);
    accept     = coin_valid && (coin_sel != 2'b00) && !cancel && !sum[CW] &&
                 (state == IDLE || state == COLLECT);
    // Any presented coin that is not accepted is rejected, whatever the reason.
    reject_nxt = coin_valid && !accept;

    case (state)
      IDLE, COLLECT: begin
        if (accept) begin
          credit_nxt = sum[CW-1:0];
          state_nxt  = (sum[CW-1:0] >= PRICE_W) ? VEND : COLLECT;
        end else if (state == COLLECT && (cancel || tmo_hit)) begin
          state_nxt = REFUND;
        end
      end
      VEND: begin
        credit_nxt = credit - PRICE_W;
        state_nxt  = (credit_nxt != '0) ? REFUND : IDLE;
      end
      REFUND: begin
        if (change_ack) begin
          credit_nxt = '0;
          state_nxt  = IDLE;
        end
      end
      default: begin
        credit_nxt = '0;
        state_nxt  = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state        <= IDLE;
      credit       <= '0;
      vend         <= 1'b0;
      coin_reject  <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      vend         <= (state_nxt == VEND);
      coin_reject  <= reject_nxt;
      change_valid <= (state_nxt == REFUND);
      change_amt   <= (state_nxt == REFUND) ? credit_nxt : '0;
      busy         <= (state_nxt == VEND) || (state_nxt == REFUND);
    end
  end

endmodule

// File: tb/tb_vending_ctrl.sv
module tb_vending_ctrl;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;

  // default-parameter instance
  logic       coin_valid = 1'b0;
  logic [1:0] coin_sel = 2'b00;
  logic       cancel = 1'b0;
  logic       change_ack = 1'b0;
  logic       vend, coin_reject, change_valid, busy;
  logic [7:0] change_amt, credit;

  // narrow instance: CW=5, PRICE=30, TIMEOUT_CYC=8
  logic       coin_valid6 = 1'b0;
  logic [1:0] coin_sel6 = 2'b00;
  logic       cancel6 = 1'b0;
  logic       change_ack6 = 1'b0;
  logic       vend6, coin_reject6, change_valid6, busy6;
  logic [4:0] change_amt6, credit6;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vending_ctrl u_dut (
    .clk(clk), .arstn(arstn), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .cancel(cancel), .change_ack(change_ack), .vend(vend),
    .coin_reject(coin_reject), .change_valid(change_valid),
    .change_amt(change_amt), .credit(credit), .busy(busy)
  );

  vending_ctrl #(.CW(5), .PRICE(30), .TIMEOUT_CYC(8)) u_dut6 (
    .clk(clk), .arstn(arstn), .coin_valid(coin_valid6), .coin_sel(coin_sel6),
    .cancel(cancel6), .change_ack(change_ack6), .vend(vend6),
    .coin_reject(coin_reject6), .change_valid(change_valid6),
    .change_amt(change_amt6), .credit(credit6), .busy(busy6)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] sel);
    coin_valid = 1'b1;
    coin_sel   = sel;
    tick();
    coin_valid = 1'b0;
    coin_sel   = 2'b00;
  endtask

  task automatic ack();
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
  endtask

  initial begin
    // ---- 1: reset defaults, async reset mid-cycle ----
    #12 arstn = 1'b1;
    tick();
    check_val("rst_credit", 32'(credit), 0);
    check_val("rst_vend", 32'(vend), 0);
    check_val("rst_cv", 32'(change_valid), 0);
    check_val("rst_amt", 32'(change_amt), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_rej", 32'(coin_reject), 0);
    coin(2'b10);
    check_val("pre_arst_credit", 32'(credit), 10);
    #3 arstn = 1'b0;
    #1;
    check_val("arst_credit", 32'(credit), 0);
    check_val("arst_busy", 32'(busy), 0);
    #2 arstn = 1'b1;
    tick();

    // ---- 2: A then B -> exact price, no change ----
    coin(2'b01);
    check_val("ab_credit5", 32'(credit), 5);
    check_val("ab_vend0", 32'(vend), 0);
    coin(2'b10);
    check_val("ab_credit15", 32'(credit), 15);
    check_val("ab_vend1", 32'(vend), 1);
    check_val("ab_busy1", 32'(busy), 1);
    tick();
    check_val("ab_vend_off", 32'(vend), 0);
    check_val("ab_cv0", 32'(change_valid), 0);
    check_val("ab_credit0", 32'(credit), 0);
    check_val("ab_busy0", 32'(busy), 0);

    // ---- 3: coin C -> vend, change 10 held until ack ----
    coin(2'b11);
    check_val("c_vend", 32'(vend), 1);
    check_val("c_credit25", 32'(credit), 25);
    check_val("c_cv_early", 32'(change_valid), 0);
    tick();
    check_val("c_vend_off", 32'(vend), 0);
    check_val("c_cv", 32'(change_valid), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("c_amt_hold", 32'(change_amt), 10);
      check_val("c_busy_hold", 32'(busy), 1);
    end
    ack();
    check_val("c_cv_done", 32'(change_valid), 0);
    check_val("c_amt_done", 32'(change_amt), 0);
    check_val("c_credit_done", 32'(credit), 0);
    check_val("c_busy_done", 32'(busy), 0);

    // ---- 4: A, A, cancel -> refund 10; coin during refund rejected ----
    coin(2'b01);
    coin(2'b01);
    check_val("cx_credit10", 32'(credit), 10);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check_val("cx_cv", 32'(change_valid), 1);
    check_val("cx_amt", 32'(change_amt), 10);
    check_val("cx_vend", 32'(vend), 0);
    coin(2'b10);
    check_val("cx_rej", 32'(coin_reject), 1);
    check_val("cx_amt_keep", 32'(change_amt), 10);
    tick();
    check_val("cx_rej_off", 32'(coin_reject), 0);
    ack();
    check_val("cx_idle_credit", 32'(credit), 0);

    // ---- 5: coin with cancel same cycle; invalid coin in IDLE ----
    coin(2'b01);
    coin_valid = 1'b1;
    coin_sel   = 2'b10;
    cancel     = 1'b1;
    tick();
    coin_valid = 1'b0;
    coin_sel   = 2'b00;
    cancel     = 1'b0;
    check_val("cc_rej", 32'(coin_reject), 1);
    check_val("cc_cv", 32'(change_valid), 1);
    check_val("cc_amt", 32'(change_amt), 5);
    ack();
    coin(2'b00);
    check_val("inv_rej", 32'(coin_reject), 1);
    check_val("inv_credit", 32'(credit), 0);
    check_val("inv_cv", 32'(change_valid), 0);

    // ---- 6: CW=5, PRICE=30: overflow reject, optional timeout ----
    coin_valid6 = 1'b1;
    coin_sel6   = 2'b11;
    tick();
    check_val("n_credit25", 32'(credit6), 25);
    check_val("n_vend0", 32'(vend6), 0);
    coin_sel6 = 2'b10;
    tick();
    coin_valid6 = 1'b0;
    coin_sel6   = 2'b00;
    check_val("n_ovf_rej", 32'(coin_reject6), 1);
    check_val("n_ovf_credit", 32'(credit6), 25);
`ifdef VEND_TIMEOUT_EN
    // entry cycle and the rejected-coin cycle count toward the 8
    repeat (6) tick();
    check_val("n_tmo_early", 32'(change_valid6), 0);
    tick();
    check_val("n_tmo_cv", 32'(change_valid6), 1);
    check_val("n_tmo_amt", 32'(change_amt6), 25);
`else
    repeat (20) tick();
    check_val("n_hold_credit", 32'(credit6), 25);
    check_val("n_hold_cv", 32'(change_valid6), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vending_ctrl.md
Name: vending_ctrl

Overview:
Parametrised coin-accumulating vending controller: three coin denominations, a configurable price, a credit register, cancel/refund and change return over a valid/ack handshake. Successor to the fixed-price vending FSM; sits between the coin acceptor front-end and the dispense/change mechanism. One clock domain, Moore-style outputs.

Parameters:
CW, 8, credit/change width in bits (max credit 2^CW-1)
PRICE, 15, item price in credit units; legal range 1..2^CW-1
COIN_A, 5, value of coin_sel=2'b01
COIN_B, 10, value of coin_sel=2'b10
COIN_C, 25, value of coin_sel=2'b11
TIMEOUT_CYC, 1000, inactivity limit in cycles (used only with VEND_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
arstn  input  1  asynchronous active-low reset
coin_valid  input  1  coin presented this cycle
coin_sel  input  2  denomination; 2'b00 is invalid
cancel  input  1  request refund of current credit
change_ack  input  1  change mechanism accepted change_amt
vend  output  1  one-cycle dispense pulse
coin_reject  output  1  one-cycle pulse, presented coin not accepted
change_valid  output  1  change/refund pending
change_amt  output  CW  change/refund value, stable while change_valid=1
credit  output  CW  current credit
busy  output  1  high in VEND or REFUND

Behaviour:
- Reset (async, arstn=0): state IDLE, credit=0, all outputs 0 immediately; pending change is discarded. Leaving reset is synchronous to clk.
- States: IDLE (credit=0), COLLECT, VEND, REFUND. All outputs registered.
- Coin accept (IDLE/COLLECT only): coin_valid=1, coin_sel!=0, cancel=0, credit+value <= 2^CW-1 -> credit <= credit+value at that edge. Sum computed at CW+1 bits.
- Coin reject: coin_valid=1 and any of: coin_sel=0, sum overflow, cancel=1 same cycle, state VEND/REFUND -> coin_reject=1 next cycle for one cycle, credit unchanged.
- Transitions at the accepting edge: new credit >= PRICE -> VEND; else new credit > 0 -> COLLECT.
- VEND: vend=1 for exactly one cycle; next edge credit <= credit-PRICE; remainder>0 -> REFUND, else IDLE (credit=0).
- Latency: coin edge N -> vend high during cycle N+1 -> change_valid high from cycle N+2.
- cancel in COLLECT -> REFUND with full credit, no vend. cancel ignored in IDLE/VEND/REFUND.
- REFUND: change_valid=1, change_amt=credit, held stable until change_ack=1 at an edge; then credit<=0, change_valid<=0, state IDLE. change_ack outside REFUND ignored.
- change_amt=0 whenever change_valid=0.
- busy=1 in VEND and REFUND.
- Elaboration error if PRICE=0 or PRICE > 2^CW-1 or any coin value=0.

Optional Feature:
VEND_TIMEOUT_EN: defined -> counter of ceil(log2(TIMEOUT_CYC+1)) bits, cleared on every accepted coin and on entry to COLLECT, incremented each COLLECT cycle; at TIMEOUT_CYC consecutive cycles without an accepted coin, controller enters REFUND exactly as for cancel. Undefined -> no counter; COLLECT holds credit indefinitely.

Test Plan:
1. Defaults; credit=10 in COLLECT, pulse arstn low mid-cycle -> credit=0, all outputs 0 without clock edge; first coin after release accepted normally.
2. Coin A then coin B on consecutive cycles -> credit 5, 15; vend=1 for one cycle; change_valid never asserted; back to IDLE with credit=0.
3. Single coin C -> vend pulse, then change_valid=1, change_amt=10; hold change_ack=0 for 3 cycles -> change_amt stable at 10, busy=1; assert change_ack -> IDLE, credit=0.
4. Coin A, coin A, then cancel -> REFUND, change_amt=10, no vend; coin B during REFUND -> coin_reject pulse, change_amt stays 10.
5. Credit=5, coin_valid with coin_sel=B and cancel same cycle -> coin_reject, refund change_amt=5; coin_valid with coin_sel=0 in IDLE -> coin_reject, credit stays 0.
6. CW=5, PRICE=30: coin C (credit 25) then coin B (35>31) -> coin_reject, credit stays 25; with VEND_TIMEOUT_EN and TIMEOUT_CYC=8, no further coins -> REFUND with change_amt=25 after 8 COLLECT cycles.
